// File: rtl/skullfet_inv_sequencer_if.sv
// Control/status bundle between the logic-analyser side (master) and the
// SKULLFET inverter self-test sequencer (slave).
interface skullfet_inv_sequencer_if #(
  parameter int CNT_W    = 16,
  parameter int SETTLE_W = 8
);
  logic                start;
  logic                abort;
  logic                mode;
  logic [CNT_W-1:0]    num_vectors;
  logic [SETTLE_W-1:0] settle_cycles;
  logic                busy;
  logic                done;
  logic                pass;
  logic [CNT_W-1:0]    vec_count;
  logic [CNT_W-1:0]    err_count;
  logic [CNT_W-1:0]    first_err_idx;
  logic [CNT_W-1:0]    y_edges;

  modport master (
    output start, abort, mode, num_vectors, settle_cycles,
    input  busy, done, pass, vec_count, err_count, first_err_idx, y_edges
  );

  modport slave (
    input  start, abort, mode, num_vectors, settle_cycles,
    output busy, done, pass, vec_count, err_count, first_err_idx, y_edges
  );
endinterface

// File: rtl/skullfet_inv_sequencer.sv
// Self-test sequencer for the SKULLFET inverter: drives A, waits, samples synchronized Y, counts errors.
// Optional synchronized-Y edge counter is built when SKULLFET_SEQ_EDGE_CNT_EN is defined.
module skullfet_inv_sequencer #(
  parameter int          CNT_W     = 16,
  parameter int          SETTLE_W  = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  skullfet_inv_sequencer_if.slave  ctl,
  output logic                     dut_a,
  input  logic                     dut_y
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DRIVE  = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_SAMPLE = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [SETTLE_W:0] SETTLE_ONE = (SETTLE_W+1)'(1);
  localparam logic [SETTLE_W:0] SETTLE_TWO = (SETTLE_W+1)'(2);

  logic [2:0]          state_q, state_d;
  logic                y_m_q, y_s_q;
  logic                dut_a_q, dut_a_d;
  logic [15:0]         lfsr_q, lfsr_d;
  logic                mode_q, mode_d;
  logic [CNT_W-1:0]    nvec_q, nvec_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [SETTLE_W:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]    vec_q, vec_d;
  logic [CNT_W-1:0]    err_q, err_d;
  logic [CNT_W-1:0]    first_q, first_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;

  logic                busy;
  logic                mismatch;
  logic                lfsr_fb;
  logic [CNT_W-1:0]    vec_inc;

  assign busy     = (state_q == S_DRIVE) || (state_q == S_SETTLE) || (state_q == S_SAMPLE);
  // An ideal inverter gives y_s == ~dut_a, so equality is a failure.
  assign mismatch = (y_s_q == dut_a_q);
  assign lfsr_fb  = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
  assign vec_inc  = vec_q + CNT_ONE;

  always_comb begin
    state_d  = state_q;
    dut_a_d  = dut_a_q;
    lfsr_d   = lfsr_q;
    mode_d   = mode_q;
    nvec_d   = nvec_q;
    settle_d = settle_q;
    cnt_d    = cnt_q;
    vec_d    = vec_q;
    err_d    = err_q;
    first_d  = first_q;
    done_d   = 1'b0;
    pass_d   = pass_q;
    case (state_q)
      S_IDLE: begin
        if (ctl.start) begin
          vec_d   = '0;
          err_d   = '0;
          first_d = '1;
          if (ctl.num_vectors != '0) begin
            mode_d   = ctl.mode;
            nvec_d   = ctl.num_vectors;
            settle_d = ctl.settle_cycles;
            lfsr_d   = LFSR_SEED;
            state_d  = S_DRIVE;
          end else begin
            done_d = 1'b1;
            pass_d = 1'b1;
          end
        end
      end
      S_DRIVE: begin
        if (ctl.abort) begin
          state_d = S_IDLE;
          pass_d  = 1'b0;
        end else begin
          if (mode_q) begin
            dut_a_d = lfsr_q[0];
            lfsr_d  = {lfsr_fb, lfsr_q[15:1]};
          end else begin
            dut_a_d = ~dut_a_q;
          end
          // Two extra cycles cover the Y synchronizer latency.
          cnt_d   = {1'b0, settle_q} + SETTLE_TWO;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (ctl.abort) begin
          state_d = S_IDLE;
          pass_d  = 1'b0;
        end else if (cnt_q == '0) begin
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q - SETTLE_ONE;
        end
      end
      S_SAMPLE: begin
        if (ctl.abort) begin
          state_d = S_IDLE;
          pass_d  = 1'b0;
        end else begin
          vec_d = vec_inc;
          if (mismatch) begin
            if (err_q != '1) err_d = err_q + CNT_ONE;
            if (err_q == '0) first_d = vec_q;
          end
          if (vec_inc == nvec_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            pass_d  = (err_q == '0) && !mismatch;
          end else begin
            state_d = S_DRIVE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q  <= S_IDLE;
      y_m_q    <= 1'b0;
      y_s_q    <= 1'b0;
      dut_a_q  <= 1'b0;
      lfsr_q   <= LFSR_SEED;
      mode_q   <= 1'b0;
      nvec_q   <= '0;
      settle_q <= '0;
      cnt_q    <= '0;
      vec_q    <= '0;
      err_q    <= '0;
      first_q  <= '1;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      y_m_q    <= dut_y;
      y_s_q    <= y_m_q;
      dut_a_q  <= dut_a_d;
      lfsr_q   <= lfsr_d;
      mode_q   <= mode_d;
      nvec_q   <= nvec_d;
      settle_q <= settle_d;
      cnt_q    <= cnt_d;
      vec_q    <= vec_d;
      err_q    <= err_d;
      first_q  <= first_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
    end
  end

`ifdef SKULLFET_SEQ_EDGE_CNT_EN
  logic             y_prev_q;
  logic [CNT_W-1:0] edges_q, edges_d;

  always_comb begin
    edges_d = edges_q;
    if (state_q == S_IDLE && ctl.start) begin
      edges_d = '0;
    end else if (busy && (y_s_q != y_prev_q) && (edges_q != '1)) begin
      edges_d = edges_q + CNT_ONE;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      y_prev_q <= 1'b0;
      edges_q  <= '0;
    end else begin
      y_prev_q <= y_s_q;
      edges_q  <= edges_d;
    end
  end

  assign ctl.y_edges = edges_q;
`else
  assign ctl.y_edges = '0;
`endif

  assign dut_a             = dut_a_q;
  assign ctl.busy          = busy;
  assign ctl.done          = done_q;
  assign ctl.pass          = pass_q;
  assign ctl.vec_count     = vec_q;
  assign ctl.err_count     = err_q;
  assign ctl.first_err_idx = first_q;

endmodule
